// File: rtl/ramio_port_arbiter_pkg.sv
// Shared port-A constants, request control type and helpers for the RAMIO arbiters.
package ramio_pkg;

    localparam logic [1:0] SIZE_NONE = 2'b00;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    localparam int unsigned RE_SIGN = 2;

    typedef struct packed {
        logic [1:0] we;
        logic [2:0] re;
    } ramio_ctl_t;

    // A master asserting write and read together gets the write; the read is dropped.
    function automatic ramio_ctl_t f_norm_ctl(input logic [1:0] we, input logic [2:0] re);
        ramio_ctl_t c;
        c.we = we;
        c.re = (we != SIZE_NONE) ? 3'b000 : re;
        return c;
    endfunction

    function automatic logic f_is_read(input ramio_ctl_t c);
        return (c.we == SIZE_NONE) && (c.re[1:0] != SIZE_NONE);
    endfunction

endpackage

// File: rtl/ramio_port_arbiter_if.sv
// Two-master request/response bundle plus the shared RAMIO port A (optional m1_lock: RAMIO_ARB_LOCK_EN).
interface ramio_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  m0_req,    m1_req;
    logic [1:0]            m0_we,     m1_we;
    logic [2:0]            m0_re,     m1_re;
    logic [ADDR_WIDTH+1:0] m0_addr,   m1_addr;
    logic [DATA_WIDTH-1:0] m0_din,    m1_din;
    logic                  m0_gnt,    m1_gnt;
    logic [DATA_WIDTH-1:0] m0_dout,   m1_dout;
    logic                  m0_rvalid, m1_rvalid;
`ifdef RAMIO_ARB_LOCK_EN
    logic                  m1_lock;
`endif
    logic [1:0]            weA;
    logic [2:0]            reA;
    logic [ADDR_WIDTH+1:0] addrA;
    logic [DATA_WIDTH-1:0] dinA;
    logic [DATA_WIDTH-1:0] doutA;

    modport slave (
`ifdef RAMIO_ARB_LOCK_EN
        input  m1_lock,
`endif
        input  m0_req, m0_we, m0_re, m0_addr, m0_din,
        input  m1_req, m1_we, m1_re, m1_addr, m1_din,
        input  doutA,
        output m0_gnt, m0_dout, m0_rvalid,
        output m1_gnt, m1_dout, m1_rvalid,
        output weA, reA, addrA, dinA
    );

    modport master (
`ifdef RAMIO_ARB_LOCK_EN
        output m1_lock,
`endif
        output m0_req, m0_we, m0_re, m0_addr, m0_din,
        output m1_req, m1_we, m1_re, m1_addr, m1_din,
        output doutA,
        input  m0_gnt, m0_dout, m0_rvalid,
        input  m1_gnt, m1_dout, m1_rvalid,
        input  weA, reA, addrA, dinA
    );
endinterface

// File: rtl/ramio_port_arbiter_rr_arb2.sv
// Two-way round-robin grant; i_lock masks requester 0 entirely.
module rr_arb2
    import ramio_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_lock,
    output logic [1:0] o_gnt
);
    logic       r_last_gnt;
    logic [1:0] w_req;

    always_comb begin
        w_req = i_req;
        if (i_lock) w_req[0] = 1'b0;
        o_gnt = '0;
        if (rst) begin
            if (w_req == 2'b11) o_gnt = r_last_gnt ? 2'b01 : 2'b10;
            else                o_gnt = w_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)          r_last_gnt <= 1'b1;
        else if (o_gnt[0]) r_last_gnt <= 1'b0;
        else if (o_gnt[1]) r_last_gnt <= 1'b1;
    end
endmodule

// File: rtl/ramio_port_arbiter.sv
// Shares RAMIO port A between two masters with round-robin grant and read-response routing.
// Optional M1 bus lock via `define RAMIO_ARB_LOCK_EN.
module ramio_port_arbiter
    import ramio_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    ramio_port_arbiter_if.slave bus
);
    typedef struct packed {
        ramio_ctl_t            ctl;
        logic [ADDR_WIDTH+1:0] addr;
        logic [DATA_WIDTH-1:0] din;
    } porta_req_t;

    porta_req_t w_pr0, w_pr1, w_sel;
    logic       w_rd0, w_rd1, w_haz0, w_haz1, w_gnt_rd, w_lock;
    logic       w_rv0, w_rv1;
    logic [1:0] w_req, w_gnt;
    logic       r_rd_pend, r_rd_owner, r_rd_sign;

    always_comb begin
        w_pr0.ctl  = f_norm_ctl(bus.m0_we, bus.m0_re);
        w_pr0.addr = bus.m0_addr;
        w_pr0.din  = bus.m0_din;
        w_pr1.ctl  = f_norm_ctl(bus.m1_we, bus.m1_re);
        w_pr1.addr = bus.m1_addr;
        w_pr1.din  = bus.m1_din;
    end

    // A read whose sign mode differs from the in-flight response must wait, since reA[2] is shared.
    assign w_rd0  = f_is_read(w_pr0.ctl);
    assign w_rd1  = f_is_read(w_pr1.ctl);
    assign w_haz0 = r_rd_pend && w_rd0 && (bus.m0_re[RE_SIGN] != r_rd_sign);
    assign w_haz1 = r_rd_pend && w_rd1 && (bus.m1_re[RE_SIGN] != r_rd_sign);
    assign w_req  = {bus.m1_req & ~w_haz1, bus.m0_req & ~w_haz0};

`ifdef RAMIO_ARB_LOCK_EN
    logic r_lock_own;
    always_ff @(posedge clk) begin
        if (!rst)              r_lock_own <= 1'b0;
        else if (!bus.m1_lock) r_lock_own <= 1'b0;
        else if (w_gnt[1])     r_lock_own <= 1'b1;
    end
    assign w_lock = r_lock_own;
`else
    assign w_lock = 1'b0;
`endif

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .i_req  (w_req),
        .i_lock (w_lock),
        .o_gnt  (w_gnt)
    );

    assign bus.m0_gnt = w_gnt[0];
    assign bus.m1_gnt = w_gnt[1];
    assign w_gnt_rd   = (w_gnt[0] && w_rd0) || (w_gnt[1] && w_rd1);

    always_comb begin
        w_sel        = '0;
        w_sel.ctl.re = {r_rd_sign, 2'b00};
        if (w_gnt[0])      w_sel = w_pr0;
        else if (w_gnt[1]) w_sel = w_pr1;
        if (!rst)          w_sel = '0;
        bus.weA   = w_sel.ctl.we;
        bus.reA   = w_sel.ctl.re;
        bus.addrA = w_sel.addr;
        bus.dinA  = w_sel.din;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
            r_rd_sign  <= 1'b0;
        end else begin
            r_rd_pend <= w_gnt_rd;
            if (w_gnt_rd) begin
                r_rd_owner <= w_gnt[1];
                r_rd_sign  <= w_gnt[1] ? bus.m1_re[RE_SIGN] : bus.m0_re[RE_SIGN];
            end
        end
    end

    assign w_rv0         = rst && r_rd_pend && !r_rd_owner;
    assign w_rv1         = rst && r_rd_pend &&  r_rd_owner;
    assign bus.m0_rvalid = w_rv0;
    assign bus.m1_rvalid = w_rv1;
    assign bus.m0_dout   = w_rv0 ? bus.doutA : '0;
    assign bus.m1_dout   = w_rv1 ? bus.doutA : '0;
endmodule
